// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a programmable pattern and mask, optional overlapping
// matches, valid qualification and a saturating match counter.
module seq_pattern_detector #(
    parameter int               PAT_W        = 8,
    parameter int               CNT_W        = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT  = 8'b0111_1110,
    parameter logic [PAT_W-1:0] DEFAULT_MASK = {PAT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             overlap_en,
    input  logic             clr_cnt,
    output logic             find,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             armed
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);

    typedef enum logic {FILL, HUNT} state_t;

    state_t           state;
    logic [PAT_W-1:0] hist, pat, mask, nh;
    logic [FW-1:0]    fill, len, fill_nxt;
    logic [FW:0]      fill_p1;
    logic             reach, hit;

    // Effective pattern length: one past the highest compared bit.
    always_comb begin
        len = '0;
        for (int i = 0; i < PAT_W; i++)
            if (mask[i]) len = FW'(i + 1);
    end

    assign nh       = {hist[PAT_W-2:0], in_bit};
    assign fill_p1  = {1'b0, fill} + (FW+1)'(1);
    assign fill_nxt = (fill == FILL_MAX) ? fill : fill_p1[FW-1:0];
    assign reach    = (len != '0) && (fill_p1 >= {1'b0, len});
    assign hit      = in_valid && !cfg_load && reach && (((nh ^ pat) & mask) == '0);
    assign armed    = (state == HUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            hist      <= '0;
            fill      <= '0;
            pat       <= DEFAULT_PAT;
            mask      <= DEFAULT_MASK;
            find      <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            find <= hit;

            if (clr_cnt) begin
                match_cnt <= hit ? CNT_W'(1) : '0;
                cnt_sat   <= hit && (CNT_W == 1);
            end else if (hit && match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + CNT_W'(1);
                if (match_cnt == CNT_MAX - CNT_W'(1)) cnt_sat <= 1'b1;
            end

            if (cfg_load) begin
                pat   <= cfg_pattern;
                mask  <= cfg_mask;
                hist  <= '0;
                fill  <= '0;
                state <= FILL;
            end else if (in_valid) begin
                if (hit && !overlap_en) begin
                    // Non-overlapping: the matched bits may not seed the next match.
                    hist  <= '0;
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    hist <= nh;
                    fill <= fill_nxt;
                    if (reach) state <= HUNT;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench: a bit-queue model predicts find/armed/match_cnt per cycle; a second
// instance with a 3-bit counter covers saturation.
module tb_seq_pattern_detector;
    localparam int PAT_W = 8;

    logic             clk = 0, rst = 1;
    logic             in_valid = 0, in_bit = 0, cfg_load = 0, overlap_en = 0, clr_cnt = 0;
    logic [PAT_W-1:0] cfg_pattern = '0, cfg_mask = '0;
    logic             find, cnt_sat, armed, find3, sat3, armed3;
    logic [7:0]       match_cnt;
    logic [2:0]       cnt3;

    typedef struct {bit f; bit a; int unsigned c;} exp_t;
    exp_t        sb[$];
    bit          mq[$];
    logic [7:0]  mpat;
    logic [7:0]  mmask;
    int          ml;
    int unsigned mcnt;
    int          tests = 0, fails = 0;
    logic [7:0]  flag = 8'h7E;

    always #5 clk = ~clk;

    seq_pattern_detector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .find(find), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .armed(armed)
    );

    seq_pattern_detector #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .find(find3), .match_cnt(cnt3), .cnt_sat(sat3), .armed(armed3)
    );

    task automatic model_reset();
        mq.delete(); mpat = 8'h7E; mmask = 8'hFF; ml = 8; mcnt = 0;
    endtask

    function automatic bit mdl_match();
        if (ml == 0 || mq.size() < ml) return 0;
        for (int i = 0; i < ml; i++)
            if (mmask[i] && mq[mq.size()-1-i] != mpat[i]) return 0;
        return 1;
    endfunction

    task automatic step(input bit v, input bit b, input bit clr);
        bit m;
        exp_t e;
        m = 0;
        if (v) begin
            mq.push_back(b);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            m = mdl_match();
            if (m && !overlap_en) mq.delete();
        end
        if (clr) mcnt = m ? 1 : 0;
        else if (m && mcnt < 255) mcnt++;
        e.f = m; e.a = (ml > 0 && mq.size() >= ml); e.c = mcnt;
        sb.push_back(e);
        in_valid = v; in_bit = b; clr_cnt = clr;
        @(posedge clk); #1;
        in_valid = 0; clr_cnt = 0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [7:0] m);
        exp_t e;
        mpat = p; mmask = m; ml = 0;
        for (int i = PAT_W - 1; i >= 0; i--) if (m[i]) begin ml = i + 1; break; end
        mq.delete();
        e.f = 0; e.a = 0; e.c = mcnt;
        sb.push_back(e);
        cfg_load = 1; cfg_pattern = p; cfg_mask = m; in_valid = 1; in_bit = 1'($urandom);
        @(posedge clk); #1;
        cfg_load = 0; in_valid = 0;
    endtask

    task automatic test_reset();
        tests++;
        if (find !== 0 || match_cnt !== 0 || cnt_sat !== 0 || armed !== 0) begin
            fails++;
            $display("FAIL reset: find/cnt/sat/armed=%b/%0d/%b/%b want 0/0/0/0",
                     find, match_cnt, cnt_sat, armed);
        end
    endtask

    task automatic test_flag();
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            step(1, flag[i], 0);
            e = sb.pop_front(); tests++;
            if (find !== e.f || armed !== e.a || match_cnt !== 8'(e.c)) begin
                fails++;
                $display("FAIL flag bit%0d: find/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, find, armed, match_cnt, e.f, e.a, e.c);
            end
        end
        tests++;
        if (find !== 1 || match_cnt !== 1) begin
            fails++; $display("FAIL flag_end: find/cnt=%b/%0d want 1/1", find, match_cnt);
        end
        step(0, 0, 0); void'(sb.pop_front()); tests++;
        if (find !== 0) begin fails++; $display("FAIL flag_pulse: find=%b want 0", find); end
    endtask

    task automatic test_overlap();
        exp_t e;
        int   nf;
        logic [5:0] bits = 6'b010101;
        for (int ov = 1; ov >= 0; ov--) begin
            overlap_en = 1'(ov);
            do_cfg(8'h05, 8'h0F); void'(sb.pop_front());
            nf = 0;
            for (int i = 5; i >= 0; i--) begin
                step(1, bits[i], 0);
                e = sb.pop_front(); tests++;
                if (find) nf++;
                if (find !== e.f || armed !== e.a || match_cnt !== 8'(e.c)) begin
                    fails++;
                    $display("FAIL overlap%0d bit%0d: find/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                             ov, i, find, armed, match_cnt, e.f, e.a, e.c);
                end
            end
            tests++;
            if (nf !== (ov ? 2 : 1)) begin
                fails++; $display("FAIL overlap%0d_count: finds=%0d want %0d", ov, nf, ov ? 2 : 1);
            end
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        int   nf = 0;
        overlap_en = 0;
        do_cfg(8'h7E, 8'hFF); void'(sb.pop_front());
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < 4; g++) begin
                if (g == 0) step(1, flag[i], 0); else step(0, ~flag[i], 0);
                e = sb.pop_front(); tests++;
                if (find) nf++;
                if (find !== e.f || armed !== e.a || match_cnt !== 8'(e.c)) begin
                    fails++;
                    $display("FAIL gaps bit%0d gap%0d: find/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                             i, g, find, armed, match_cnt, e.f, e.a, e.c);
                end
            end
        end
        tests++;
        if (nf !== 1) begin fails++; $display("FAIL gaps_count: finds=%0d want 1", nf); end
    endtask

    task automatic test_saturate();
        overlap_en = 0;
        do_cfg(8'h7E, 8'hFF); void'(sb.pop_front());
        step(0, 0, 1); void'(sb.pop_front());
        for (int n = 0; n < 9; n++)
            for (int i = 7; i >= 0; i--) begin step(1, flag[i], 0); void'(sb.pop_front()); end
        tests++;
        if (cnt3 !== 3'd7 || sat3 !== 1) begin
            fails++; $display("FAIL sat3: cnt/sat=%0d/%b want 7/1", cnt3, sat3);
        end
        tests++;
        if (match_cnt !== 8'd9 || cnt_sat !== 0) begin
            fails++; $display("FAIL sat8: cnt/sat=%0d/%b want 9/0", match_cnt, cnt_sat);
        end
        step(0, 0, 1); void'(sb.pop_front()); tests++;
        if (cnt3 !== 0 || sat3 !== 0 || match_cnt !== 0) begin
            fails++; $display("FAIL clr: cnt3/sat3/cnt=%0d/%b/%0d want 0/0/0", cnt3, sat3, match_cnt);
        end
        for (int i = 7; i >= 0; i--) begin step(1, flag[i], i == 0); void'(sb.pop_front()); end
        tests++;
        if (cnt3 !== 1 || sat3 !== 0 || match_cnt !== 1 || find !== 1) begin
            fails++;
            $display("FAIL clr_on_match: cnt3/sat3/cnt/find=%0d/%b/%0d/%b want 1/0/1/1",
                     cnt3, sat3, match_cnt, find);
        end
    endtask

    task automatic test_cfg_and_rst();
        exp_t e;
        overlap_en = 0;
        for (int i = 7; i >= 3; i--) begin step(1, flag[i], 0); void'(sb.pop_front()); end
        do_cfg(8'h7E, 8'hFF);
        e = sb.pop_front(); tests++;
        if (find !== 0 || armed !== 0 || match_cnt !== 8'(e.c)) begin
            fails++; $display("FAIL cfg_load: find/armed/cnt=%b/%b/%0d want 0/0/%0d",
                              find, armed, match_cnt, e.c);
        end
        for (int i = 2; i >= 0; i--) begin
            step(1, flag[i], 0);
            e = sb.pop_front(); tests++;
            if (find !== e.f || armed !== e.a || match_cnt !== 8'(e.c)) begin
                fails++;
                $display("FAIL cfg_tail bit%0d: find/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, find, armed, match_cnt, e.f, e.a, e.c);
            end
        end
        for (int i = 7; i >= 0; i--) begin step(1, flag[i], 0); void'(sb.pop_front()); end
        tests++;
        if (find !== 1) begin fails++; $display("FAIL cfg_full: find=%b want 1", find); end
        for (int i = 7; i >= 4; i--) begin step(1, flag[i], 0); void'(sb.pop_front()); end
        step(1, 1, 0); void'(sb.pop_front());
        #2 rst = 1; #1;
        model_reset();
        tests++;
        if (find !== 0 || match_cnt !== 0 || cnt_sat !== 0 || armed !== 0 || cnt3 !== 0) begin
            fails++;
            $display("FAIL mid_rst: find/cnt/sat/armed/cnt3=%b/%0d/%b/%b/%0d want all 0",
                     find, match_cnt, cnt_sat, armed, cnt3);
        end
        @(posedge clk); #1 rst = 0;
        for (int i = 2; i >= 0; i--) begin
            step(1, flag[i], 0);
            e = sb.pop_front(); tests++;
            if (find !== e.f || armed !== e.a || match_cnt !== 8'(e.c)) begin
                fails++;
                $display("FAIL post_rst bit%0d: find/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, find, armed, match_cnt, e.f, e.a, e.c);
            end
        end
    endtask

    task automatic test_mask_zero();
        exp_t e;
        overlap_en = 1;
        do_cfg(8'($urandom), 8'h00); void'(sb.pop_front());
        for (int n = 0; n < 200; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 0);
            e = sb.pop_front(); tests++;
            if (find !== 0 || armed !== 0 || find !== e.f || match_cnt !== 8'(e.c)) begin
                fails++;
                $display("FAIL mask0 n%0d: find/armed/cnt=%b/%b/%0d want 0/0/%0d",
                         n, find, armed, match_cnt, e.c);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 0;
        test_flag();
        test_overlap();
        test_gaps();
        test_saturate();
        test_cfg_and_rst();
        test_mask_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end
endmodule
